p2p_egress_wrr_sched: RTL

Packet-granular weighted round-robin scheduler for the P2P egress direction of the host route port. Drains two first-word-fall-through egress queues (queue 0: traffic from the NIC, queue 1: traffic from the link) and emits one merged, never-interleaved packet stream toward the P2P up channel formatter. Per-queue weights come from a software read/write register. One registered output stage provides the valid/ready handshake.

---
 rtl/p2p_egress_wrr_sched_if.sv | 25 ++
 rtl/p2p_egress_wrr_sched.sv | 127 ++++++++++++
 2 files changed

// File: rtl/p2p_egress_wrr_sched_if.sv
// Egress queue pop/data and merged output handshake bundle for p2p_egress_wrr_sched.
// master = scheduler side, slave = queues plus downstream formatter side.
interface p2p_egress_wrr_sched_if #(
   parameter int unsigned EGRESS_QUEUE_WIDTH = 288
);
   logic                          i_q0_empty;
   logic                          o_q0_rd_en;
   logic [EGRESS_QUEUE_WIDTH-1:0] iv_q0_data;
   logic                          i_q1_empty;
   logic                          o_q1_rd_en;
   logic [EGRESS_QUEUE_WIDTH-1:0] iv_q1_data;
   logic                          o_out_valid;
   logic [EGRESS_QUEUE_WIDTH-1:0] ov_out_data;
   logic                          i_out_ready;

   modport master (
      input  i_q0_empty, iv_q0_data, i_q1_empty, iv_q1_data, i_out_ready,
      output o_q0_rd_en, o_q1_rd_en, o_out_valid, ov_out_data
   );

   modport slave (
      output i_q0_empty, iv_q0_data, i_q1_empty, iv_q1_data, i_out_ready,
      input  o_q0_rd_en, o_q1_rd_en, o_out_valid, ov_out_data
   );
endinterface

// File: rtl/p2p_egress_wrr_sched.sv
// Packet-granular two-queue weighted round-robin egress scheduler with one registered output stage.
// Optional per-queue packet counters enabled by defining P2P_SCHED_STAT_EN.
module p2p_egress_wrr_sched #(
   parameter int unsigned EGRESS_QUEUE_WIDTH = 288,
   parameter int unsigned WEIGHT_WIDTH       = 8,
   parameter int unsigned CNT_WIDTH          = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          rw_data,
   p2p_egress_wrr_sched_if.master bus,
   output logic [CNT_WIDTH-1:0] ov_q0_pkt_cnt,
   output logic [CNT_WIDTH-1:0] ov_q1_pkt_cnt
);
   localparam int unsigned END_BIT = 257;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] XFER0 = 2'd1;
   localparam logic [1:0] XFER1 = 2'd2;

   logic [1:0]                    state, state_nxt;
   logic                          pref, pref_nxt;
   logic [WEIGHT_WIDTH-1:0]       credit, credit_nxt;
   logic                          out_valid;
   logic [EGRESS_QUEUE_WIDTH-1:0] out_data;

   logic [WEIGHT_WIDTH-1:0]       w0_raw, w1_raw, w0_eff, w1_eff, wp_eff;
   logic                          pref_empty, other_empty;
   logic                          out_free, q0_rd, q1_rd, pop_end;
   logic [EGRESS_QUEUE_WIDTH-1:0] pop_data;
   logic                          unused_rw;

   assign unused_rw = ^rw_data[31:2*WEIGHT_WIDTH];

   // A zero weight still grants one packet per turn
   assign w0_raw = rw_data[WEIGHT_WIDTH-1:0];
   assign w1_raw = rw_data[2*WEIGHT_WIDTH-1:WEIGHT_WIDTH];
   assign w0_eff = (w0_raw == '0) ? WEIGHT_WIDTH'(1) : w0_raw;
   assign w1_eff = (w1_raw == '0) ? WEIGHT_WIDTH'(1) : w1_raw;
   assign wp_eff = pref ? w1_eff : w0_eff;

   assign pref_empty  = pref ? bus.i_q1_empty : bus.i_q0_empty;
   assign other_empty = pref ? bus.i_q0_empty : bus.i_q1_empty;

   // Pops are gated by reset so an in-flight packet stops draining immediately
   assign out_free = !out_valid || bus.i_out_ready;
   assign q0_rd    = rst && (state == XFER0) && !bus.i_q0_empty && out_free;
   assign q1_rd    = rst && (state == XFER1) && !bus.i_q1_empty && out_free;
   assign pop_data = q1_rd ? bus.iv_q1_data : bus.iv_q0_data;
   assign pop_end  = (q0_rd && bus.iv_q0_data[END_BIT]) || (q1_rd && bus.iv_q1_data[END_BIT]);

   assign bus.o_q0_rd_en  = q0_rd;
   assign bus.o_q1_rd_en  = q1_rd;
   assign bus.o_out_valid = out_valid;
   assign bus.ov_out_data = out_data;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         pref   <= 1'b0;
         credit <= '0;
      end else begin
         state  <= state_nxt;
         pref   <= pref_nxt;
         credit <= credit_nxt;
      end
   end

   // Scheduling decision happens only in IDLE; a granted packet runs to its end beat
   always_comb begin
      state_nxt  = state;
      pref_nxt   = pref;
      credit_nxt = credit;
      case (state)
         IDLE: begin
            if (!pref_empty && (credit < wp_eff)) begin
               state_nxt  = pref ? XFER1 : XFER0;
               credit_nxt = credit + WEIGHT_WIDTH'(1);
            end else if (!other_empty) begin
               state_nxt  = pref ? XFER0 : XFER1;
               pref_nxt   = !pref;
               credit_nxt = WEIGHT_WIDTH'(1);
            end else if (!pref_empty) begin
               state_nxt  = pref ? XFER1 : XFER0;
               credit_nxt = WEIGHT_WIDTH'(1);
            end
         end
         XFER0, XFER1: begin
            if (pop_end) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (q0_rd || q1_rd) begin
         out_valid <= 1'b1;
         out_data  <= pop_data;
      end else if (bus.i_out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef P2P_SCHED_STAT_EN
   logic [CNT_WIDTH-1:0] q0_cnt, q1_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         q0_cnt <= '0;
         q1_cnt <= '0;
      end else begin
         if (q0_rd && bus.iv_q0_data[END_BIT]) q0_cnt <= q0_cnt + CNT_WIDTH'(1);
         if (q1_rd && bus.iv_q1_data[END_BIT]) q1_cnt <= q1_cnt + CNT_WIDTH'(1);
      end
   end

   assign ov_q0_pkt_cnt = q0_cnt;
   assign ov_q1_pkt_cnt = q1_cnt;
`else
   assign ov_q0_pkt_cnt = '0;
   assign ov_q1_pkt_cnt = '0;
`endif

endmodule
